// File: rtl/uart_tx_engine_pkg.sv
// Shared definitions for the UART transmit engine: one-hot states, parity
// method codes, default FIFO depth and the per-frame configuration snapshot.
package uart_tx_engine_pkg;

    localparam int DEFAULT_FIFO_DEPTH = 128;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } tx_state_e;

    // Frame settings frozen when a byte enters the shift register
    typedef struct packed {
        logic par_en;
        logic par_bit;
        logic msb_first;
    } frame_cfg_t;

    function automatic logic parity_of(input logic [7:0] b, input logic method);
        return (^b) ^ (method == PARITY_ODD);
    endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Byte FIFO for the UART transmitter. DEPTH must be a power of two; pointers
// carry one extra wrap bit so full and empty are distinguishable.
module tx_byte_fifo #(
    parameter int DEPTH = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: byte FIFO -> holding register -> framed serial output.
// Define UART_TX_FRAME_COUNT_EN to add the 16-bit sent_count_o frame counter.
module uart_tx_engine
    import uart_tx_engine_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       n_we_i,
    output logic       p_full_o,
    output logic       p_empty_o,
    input  logic       BaudSig_i,
    input  logic       p_ParityEnable_i,
    input  logic       ParityMethod_i,
    input  logic       p_BigEnd_i,
    output logic       Tx_o,
    output logic       p_busy_o,
    output logic [4:0] State_o
`ifdef UART_TX_FRAME_COUNT_EN
    ,
    output logic [15:0] sent_count_o
`endif
);

    logic       fifo_we, fifo_re, fifo_full, fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       hold_valid;
    logic [7:0] hold_data;
    logic       load;
    tx_state_e  state_q;
    logic [7:0] shift_q;
    logic [3:0] bit_cnt;
    frame_cfg_t cfg_q;
    logic       next_bit;
    logic [7:0] shift_nxt;

    // Full is a registered flag, so a write while full is dropped even if a pop frees a slot
    assign fifo_we = !n_we_i && !fifo_full;
    assign fifo_re = !hold_valid && !fifo_empty;

    tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_we),
        .wr_data (data_i),
        .rd_en   (fifo_re),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign load = BaudSig_i && hold_valid && (state_q == ST_IDLE || state_q == ST_STOP);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (load) begin
            hold_valid <= 1'b0;
        end else if (fifo_re) begin
            hold_valid <= 1'b1;
            hold_data  <= fifo_rd_data;
        end
    end

    assign next_bit  = cfg_q.msb_first ? shift_q[7] : shift_q[0];
    assign shift_nxt = cfg_q.msb_first ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};

    // Tx_o is updated on the same edge as the state, so it reflects the new state next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            Tx_o    <= 1'b1;
            shift_q <= '0;
            bit_cnt <= '0;
            cfg_q   <= '0;
        end else if (BaudSig_i) begin
            unique case (state_q)
                ST_IDLE, ST_STOP: begin
                    if (hold_valid) begin
                        state_q <= ST_START;
                        Tx_o    <= 1'b0;
                        shift_q <= hold_data;
                        cfg_q   <= '{par_en:    p_ParityEnable_i,
                                     par_bit:   parity_of(hold_data, ParityMethod_i),
                                     msb_first: p_BigEnd_i};
                    end else begin
                        state_q <= ST_IDLE;
                        Tx_o    <= 1'b1;
                    end
                end
                ST_START: begin
                    state_q <= ST_DATA;
                    Tx_o    <= next_bit;
                    shift_q <= shift_nxt;
                    bit_cnt <= '0;
                end
                ST_DATA: begin
                    if (bit_cnt == 4'd7) begin
                        state_q <= cfg_q.par_en ? ST_PARITY : ST_STOP;
                        Tx_o    <= cfg_q.par_en ? cfg_q.par_bit : 1'b1;
                    end else begin
                        Tx_o    <= next_bit;
                        shift_q <= shift_nxt;
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                ST_PARITY: begin
                    state_q <= ST_STOP;
                    Tx_o    <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    Tx_o    <= 1'b1;
                end
            endcase
        end
    end

`ifdef UART_TX_FRAME_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)                                  sent_count_o <= '0;
        else if (BaudSig_i && state_q == ST_STOP) sent_count_o <= sent_count_o + 16'd1;
    end
`endif

    assign State_o   = state_q;
    assign p_busy_o  = (state_q != ST_IDLE);
    assign p_full_o  = fifo_full;
    assign p_empty_o = fifo_empty;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: expected line bits come from a frame
// model built from byte value and settings, compared once per bit period.
module tb_uart_tx_engine;

    localparam logic [4:0] S_IDLE = 5'b00001, S_START = 5'b00010, S_DATA = 5'b00100,
                           S_PAR  = 5'b01000, S_STOP  = 5'b10000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_i = '0;
    logic       n_we_i = 1'b1;
    logic       BaudSig_i = 1'b0;
    logic       p_ParityEnable_i = 1'b0;
    logic       ParityMethod_i = 1'b0;
    logic       p_BigEnd_i = 1'b0;
    logic       p_full_o, p_empty_o, Tx_o, p_busy_o;
    logic [4:0] State_o;
`ifdef UART_TX_FRAME_COUNT_EN
    logic [15:0] sent_count_o;
`endif

    int checks = 0;
    int failures = 0;

    logic       exp_bits [11];
    logic [4:0] exp_st   [11];
    int         exp_n;

    uart_tx_engine #(.FIFO_DEPTH(128)) dut (
        .clk              (clk),
        .rst              (rst),
        .data_i           (data_i),
        .n_we_i           (n_we_i),
        .p_full_o         (p_full_o),
        .p_empty_o        (p_empty_o),
        .BaudSig_i        (BaudSig_i),
        .p_ParityEnable_i (p_ParityEnable_i),
        .ParityMethod_i   (ParityMethod_i),
        .p_BigEnd_i       (p_BigEnd_i),
        .Tx_o             (Tx_o),
        .p_busy_o         (p_busy_o),
        .State_o          (State_o)
`ifdef UART_TX_FRAME_COUNT_EN
        ,
        .sent_count_o     (sent_count_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic pe, input logic odd, input logic msb);
        p_ParityEnable_i = pe;
        ParityMethod_i   = odd;
        p_BigEnd_i       = msb;
    endtask

    task automatic write_byte(input logic [7:0] b);
        data_i = b;
        n_we_i = 1'b0;
        tick();
        n_we_i = 1'b1;
    endtask

    // Line sequence of one frame: start, 8 data bits in chosen order, optional parity, stop
    task automatic build_frame(input logic [7:0] b, input logic pe, input logic odd, input logic msb);
        int n = 0;
        exp_bits[n] = 1'b0; exp_st[n] = S_START; n++;
        for (int i = 0; i < 8; i++) begin
            exp_bits[n] = msb ? b[7-i] : b[i];
            exp_st[n]   = S_DATA;
            n++;
        end
        if (pe) begin
            exp_bits[n] = (^b) ^ odd; exp_st[n] = S_PAR; n++;
        end
        exp_bits[n] = 1'b1; exp_st[n] = S_STOP; n++;
        exp_n = n;
    endtask

    // One baud pulse followed by a mid-period sample of the line
    task automatic baud_period(output logic tx_s, output logic [4:0] st_s, output logic busy_s);
        BaudSig_i = 1'b1;
        tick();
        BaudSig_i = 1'b0;
        repeat (3) tick();
        tx_s   = Tx_o;
        st_s   = State_o;
        busy_s = p_busy_o;
        repeat (4) tick();
    endtask

    task automatic run_frame(input logic [7:0] b, input logic pe, input logic odd, input logic msb,
                             input bit scramble, input string nm);
        logic tx_s, busy_s;
        logic [4:0] st_s;
        build_frame(b, pe, odd, msb);
        for (int k = 0; k < exp_n; k++) begin
            baud_period(tx_s, st_s, busy_s);
            if (scramble && k == 0) set_cfg(1'($urandom), 1'($urandom), 1'($urandom));
            checks++;
            if (tx_s !== exp_bits[k]) begin
                failures++;
                $display("FAIL %s byte=%h tx bit%0d got=%b exp=%b", nm, b, k, tx_s, exp_bits[k]);
            end
            checks++;
            if (st_s !== exp_st[k] || busy_s !== 1'b1) begin
                failures++;
                $display("FAIL %s state bit%0d got=%b/busy=%b exp=%b/busy=1", nm, k, st_s, busy_s, exp_st[k]);
            end
        end
    endtask

    task automatic expect_idle(input string nm);
        logic tx_s, busy_s;
        logic [4:0] st_s;
        baud_period(tx_s, st_s, busy_s);
        checks++;
        if (tx_s !== 1'b1 || st_s !== S_IDLE || busy_s !== 1'b0) begin
            failures++;
            $display("FAIL %s idle got tx=%b st=%b busy=%b exp tx=1 st=00001 busy=0", nm, tx_s, st_s, busy_s);
        end
    endtask

    task automatic check_reset_state(input string nm);
        checks++;
        if (Tx_o !== 1'b1 || State_o !== S_IDLE || p_busy_o !== 1'b0 ||
            p_empty_o !== 1'b1 || p_full_o !== 1'b0) begin
            failures++;
            $display("FAIL %s got tx=%b st=%b busy=%b empty=%b full=%b exp 1/00001/0/1/0",
                     nm, Tx_o, State_o, p_busy_o, p_empty_o, p_full_o);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        check_reset_state("reset");
        rst = 1'b0;
        tick();
    endtask

    task automatic test_frames;
        set_cfg(1'b0, 1'b0, 1'b0);
        write_byte(8'h55);
        checks++;
        if (p_empty_o !== 1'b0) begin
            failures++;
            $display("FAIL write_lat empty after write got=%b exp=0", p_empty_o);
        end
        tick();
        checks++;
        if (p_empty_o !== 1'b1) begin
            failures++;
            $display("FAIL write_lat empty after pop got=%b exp=1", p_empty_o);
        end
        run_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, "lsb_55");
        expect_idle("lsb_55");

        set_cfg(1'b1, 1'b0, 1'b0);
        write_byte(8'hA3); tick();
        run_frame(8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, "even_a3");
        expect_idle("even_a3");

        set_cfg(1'b1, 1'b1, 1'b0);
        write_byte(8'hA3); tick();
        run_frame(8'hA3, 1'b1, 1'b1, 1'b0, 1'b0, "odd_a3");
        expect_idle("odd_a3");

        set_cfg(1'b0, 1'b0, 1'b1);
        write_byte(8'h01); tick();
        run_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, "msb_01");
        expect_idle("msb_01");
    endtask

    task automatic test_fifo_full;
        logic [7:0] q[$];
        logic [7:0] b;
        set_cfg(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 130; i++) begin
            b = (i == 129) ? 8'hEE : 8'(i);
            if (i == 128) begin
                checks++;
                if (p_full_o !== 1'b0) begin
                    failures++;
                    $display("FAIL fifo_full before 129th got=%b exp=0", p_full_o);
                end
            end
            if (q.size() < 129) q.push_back(b);
            write_byte(b);
        end
        checks++;
        if (p_full_o !== 1'b1 || p_empty_o !== 1'b0) begin
            failures++;
            $display("FAIL fifo_full flags got full=%b empty=%b exp full=1 empty=0", p_full_o, p_empty_o);
        end
        while (q.size() > 0) run_frame(q.pop_front(), 1'b0, 1'b0, 1'b0, 1'b0, "fifo_drain");
        expect_idle("fifo_drain");
        checks++;
        if (p_empty_o !== 1'b1 || p_full_o !== 1'b0) begin
            failures++;
            $display("FAIL fifo_drain flags got full=%b empty=%b exp full=0 empty=1", p_full_o, p_empty_o);
        end
    endtask

    task automatic test_back_to_back;
        rst = 1'b1; tick(); rst = 1'b0;
        set_cfg(1'b1, 1'b0, 1'b0);
        write_byte(8'h12);
        write_byte(8'h34);
        tick();
        run_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, "b2b_12");
        run_frame(8'h34, 1'b1, 1'b0, 1'b0, 1'b0, "b2b_34");
        expect_idle("b2b");
`ifdef UART_TX_FRAME_COUNT_EN
        checks++;
        if (sent_count_o !== 16'd2) begin
            failures++;
            $display("FAIL frame_count got=%0d exp=2", sent_count_o);
        end
`endif
    endtask

    task automatic test_reset_mid_frame;
        logic tx_s, busy_s;
        logic [4:0] st_s;
        set_cfg(1'b0, 1'b0, 1'b0);
        write_byte(8'h3C);
        write_byte(8'h5A);
        write_byte(8'h77);
        tick();
        repeat (5) baud_period(tx_s, st_s, busy_s);
        rst = 1'b1;
        tick();
        check_reset_state("reset_mid");
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            baud_period(tx_s, st_s, busy_s);
            checks++;
            if (tx_s !== 1'b1 || st_s !== S_IDLE) begin
                failures++;
                $display("FAIL reset_mid resume period%0d got tx=%b st=%b exp tx=1 st=00001", k, tx_s, st_s);
            end
        end
    endtask

    task automatic test_baud_continuous;
        logic [7:0] b;
        logic pe, odd, msb;
        b = 8'($urandom); pe = 1'b1; odd = 1'($urandom); msb = 1'($urandom);
        set_cfg(pe, odd, msb);
        build_frame(b, pe, odd, msb);
        write_byte(b); tick();
        BaudSig_i = 1'b1;
        for (int k = 0; k < exp_n; k++) begin
            tick();
            checks++;
            if (Tx_o !== exp_bits[k] || State_o !== exp_st[k]) begin
                failures++;
                $display("FAIL baud_cont byte=%h cycle%0d got tx=%b st=%b exp tx=%b st=%b",
                         b, k, Tx_o, State_o, exp_bits[k], exp_st[k]);
            end
        end
        tick();
        checks++;
        if (Tx_o !== 1'b1 || State_o !== S_IDLE) begin
            failures++;
            $display("FAIL baud_cont end got tx=%b st=%b exp tx=1 st=00001", Tx_o, State_o);
        end
        BaudSig_i = 1'b0;
        tick();
    endtask

    task automatic test_random;
        logic [7:0] b;
        logic pe, odd, msb;
        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom); pe = 1'($urandom); odd = 1'($urandom); msb = 1'($urandom);
            set_cfg(pe, odd, msb);
            write_byte(b);
            repeat ($urandom_range(1, 4)) tick();
            run_frame(b, pe, odd, msb, 1'b1, "random");
            expect_idle("random");
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_fifo_full();
        test_back_to_back();
        test_reset_mid_frame();
        test_baud_continuous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter: FIFO_DEPTH, default 128, byte FIFO depth; power of two, 4 to 256.
REQ-002 Port: clk  input  1  system clock; every flop on the rising edge.
REQ-003 Port: rst  input  1  reset; synchronous to clk, active-high.
REQ-004 Port: data_i  input  8  byte to transmit.
REQ-005 Port: n_we_i  input  1  FIFO write strobe, active-low, one byte per low cycle.
REQ-006 Port: p_full_o  output  1  FIFO full.
REQ-007 Port: p_empty_o  output  1  FIFO empty.
REQ-008 Port: BaudSig_i  input  1  one-cycle pulse per bit period, from the baud generator.
REQ-009 Port: p_ParityEnable_i  input  1  parity bit is inserted after the data bits.
REQ-010 Port: ParityMethod_i  input  1  0 = even, 1 = odd.
REQ-011 Port: p_BigEnd_i  input  1  1 = MSB first, 0 = LSB first.
REQ-012 Port: Tx_o  output  1  serial line, registered, idle high.
REQ-013 Port: p_busy_o  output  1  high in every state except IDLE.
REQ-014 Port: State_o  output  5  one-hot state {STOP,PARITY,DATA,START,IDLE}, with IDLE as bit 0.

Function
REQ-015 A write shall be accepted when n_we_i is low and p_full_o is low in the same cycle. A write while full shall be dropped, even if a pop occurs in that cycle.
REQ-016 When the holding register is empty and the FIFO is non-empty, the block shall pop one byte into the holding register in that cycle. Latency from write to holding register on an empty FIFO: 2 cycles.
REQ-017 The control fields (parity enable, parity method, bit order) shall be captured into the frame at load time. Changes mid-frame shall have no effect on the current frame.
REQ-018 IDLE -> START: on BaudSig_i with the holding register valid. The shift register shall load the holding byte and the holding register shall clear.
REQ-019 START -> DATA on BaudSig_i. DATA shall hold for 8 BaudSig_i pulses, tracked by a 4-bit bit counter.
REQ-020 After the 8th data bit: DATA -> PARITY if parity is enabled, otherwise DATA -> STOP. PARITY -> STOP on BaudSig_i.
REQ-021 STOP exit on BaudSig_i: go to START (back-to-back, no idle bit) if the holding register is valid, otherwise go to IDLE.
REQ-022 Tx_o shall follow the state one cycle after the transition cycle: START = 0, DATA = current data bit, PARITY = parity bit, STOP = 1, IDLE = 1.
REQ-023 The parity bit shall be the XOR of the 8 data bits, inverted when ParityMethod_i = 1.
REQ-024 BaudSig_i shall be ignored outside a transition condition. BaudSig_i held high continuously shall advance one state or bit per cycle.

Reset
REQ-025 While rst is high, on the next edge: Tx_o = 1, State_o = 5'b00001, p_busy_o = 0, p_empty_o = 1, p_full_o = 0. FIFO pointers, holding register, bit counter and shift register shall clear.
REQ-026 Reset mid-frame shall abort the frame. Tx_o shall return high on the next edge and the partial frame shall not resume.

Configuration
REQ-027 With macro UART_TX_FRAME_COUNT_EN defined, the block shall add output sent_count_o (16 bits). It shall increment on each STOP exit, wrap from 0xFFFF to 0, and clear on rst.
REQ-028 Without UART_TX_FRAME_COUNT_EN, the port and the counter shall be absent and the remaining behaviour shall be identical.

Structure
REQ-029 A shared package shall hold the one-hot state encodings, the parity method constants (EVEN = 0, ODD = 1) and the default FIFO depth.
REQ-030 One sub-module, tx_byte_fifo, shall hold the FIFO storage, pointers and full/empty flags. The FSM, shift register and parity logic shall live in uart_tx_engine.

Verification
REQ-031 Write 0x55, no parity, LSB first -> Tx_o per bit period: 0,1,0,1,0,1,0,1,0,1, then idle 1. p_busy_o shall drop after STOP.
REQ-032 Write 0xA3, even parity -> data bits 1,1,0,0,0,1,0,1, parity 0. The same byte with odd parity -> parity 1.
REQ-033 Write 0x01, p_BigEnd_i = 1 -> data bits 0,0,0,0,0,0,0,1.
REQ-034 With no BaudSig_i, write 130 bytes -> 129 accepted (128 FIFO + 1 holding) and p_full_o high. The 130th byte is dropped and never appears on Tx_o.
REQ-035 Write 0x12 and 0x34 back-to-back -> the second START immediately follows the first STOP with no extra idle bit. With UART_TX_FRAME_COUNT_EN, sent_count_o = 2.
REQ-036 Assert rst during DATA bit 3 -> Tx_o = 1 and State_o = 5'b00001 on the next edge, and p_empty_o = 1.
